// File: rtl/vga_pkg.sv
// Shared types and framebuffer geometry for the VGA framebuffer arbiter.
package vga_pkg;

    localparam int unsigned FB_WIDTH  = 160;
    localparam int unsigned FB_HEIGHT = 120;
    localparam int unsigned FB_DEPTH  = 19200;

    typedef enum logic [1:0] {
        StIdle,
        StFetch,
        StWrite,
        StGap
    } fb_state_e;

    function automatic logic fb_in_range(input logic [31:0] addr);
        return addr < FB_DEPTH;
    endfunction

endpackage

// File: rtl/fb_addr_gen.sv
// Scan position to framebuffer address: (v>>2)*160 + (h>>2), wrapped to AW bits.
module fb_addr_gen #(
    parameter int unsigned N  = 9,
    parameter int unsigned AW = 15
) (
    input  logic [N:0]    i_horiz_count,
    input  logic [N:0]    i_vert_count,
    output logic [AW-1:0] o_addr
);

    logic [AW-1:0] w_row;
    logic [AW-1:0] w_col;

    always_comb begin
        w_row  = AW'(i_vert_count >> 2);
        w_col  = AW'(i_horiz_count >> 2);
        o_addr = (w_row << 7) + (w_row << 5) + w_col;
    end

endmodule

// File: rtl/vga_fb_arbiter.sv
// Shares one synchronous RAM port between display pixel fetches and a writer.
// Define FB_UNDERRUN_CNT_EN to build the 16-bit dropped-fetch counter.
module vga_fb_arbiter
    import vga_pkg::*;
#(
    parameter int unsigned N        = 9,
    parameter int unsigned AW       = 15,
    parameter int unsigned DW       = 8,
    parameter int unsigned MAX_WAIT = 8
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          pix_tick,
    input  logic          disp_active,
    input  logic [N:0]    horiz_count,
    input  logic [N:0]    vert_count,
    input  logic          wr_req,
    input  logic [AW-1:0] wr_addr,
    input  logic [DW-1:0] wr_data,
    output logic          wr_ack,
    output logic          wr_err,
    output logic [AW-1:0] mem_addr,
    output logic          mem_we,
    output logic [DW-1:0] mem_wdata,
    input  logic [DW-1:0] mem_rdata,
    output logic [DW-1:0] pix_color,
    output logic          underrun,
    output logic [15:0]   underrun_count
);

    localparam logic [7:0] MaxWait = 8'(MAX_WAIT);

    fb_state_e     r_state, w_state_next;
    logic          r_pend, w_pend_next;
    logic [AW-1:0] r_pend_addr, w_pend_addr_next;
    logic [7:0]    r_wait_cnt, w_wait_next;
    logic [2:0]    r_fetch_v, r_blank_v;
    logic [DW-1:0] r_rd_buf, r_pix_color, r_mem_wdata;
    logic [AW-1:0] r_mem_addr, w_fetch_addr, w_issue_addr;
    logic          r_wr_ack, r_wr_err, r_mem_we, r_underrun;
    logic          w_tick, w_blank, w_port_ok, w_forced;
    logic          w_grant, w_issue, w_drop, w_in_range;

    fb_addr_gen #(
        .N  (N),
        .AW (AW)
    ) u_addr_gen (
        .i_horiz_count (horiz_count),
        .i_vert_count  (vert_count),
        .o_addr        (w_fetch_addr)
    );

    assign w_tick     = pix_tick & disp_active;
    assign w_blank    = pix_tick & ~disp_active;
    // Writes may only be granted when the previous cycle was not a write or its gap.
    assign w_port_ok  = (r_state == StIdle) || (r_state == StFetch);
    assign w_forced   = wr_req && (r_wait_cnt == MaxWait) && w_port_ok;
    assign w_in_range = fb_in_range(32'(wr_addr));

    always_comb begin
        w_grant          = 1'b0;
        w_issue          = 1'b0;
        w_drop           = 1'b0;
        w_issue_addr     = r_pend_addr;
        w_pend_next      = r_pend;
        w_pend_addr_next = r_pend_addr;

        if (w_forced) begin
            // Starved writer wins; the fetch due now is lost, a fresh tick takes the slot.
            w_grant          = 1'b1;
            w_drop           = r_pend | w_tick;
            w_pend_next      = r_pend & w_tick;
            w_pend_addr_next = w_fetch_addr;
        end else if (r_pend) begin
            w_issue          = 1'b1;
            w_pend_next      = w_tick;
            w_pend_addr_next = w_fetch_addr;
        end else if (w_tick) begin
            if (r_state == StIdle) begin
                w_issue      = 1'b1;
                w_issue_addr = w_fetch_addr;
            end else begin
                w_pend_next      = 1'b1;
                w_pend_addr_next = w_fetch_addr;
            end
        end else if (wr_req && w_port_ok) begin
            w_grant = 1'b1;
        end

        if (r_state == StWrite) begin
            w_state_next = StGap;
        end else if (w_grant) begin
            w_state_next = StWrite;
        end else if (w_issue) begin
            w_state_next = StFetch;
        end else begin
            w_state_next = StIdle;
        end

        if (w_grant || r_wr_ack) begin
            w_wait_next = '0;
        end else if (wr_req && (r_wait_cnt != MaxWait)) begin
            w_wait_next = r_wait_cnt + 8'd1;
        end else begin
            w_wait_next = r_wait_cnt;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state     <= StIdle;
            r_pend      <= 1'b0;
            r_pend_addr <= '0;
            r_wait_cnt  <= '0;
            r_fetch_v   <= '0;
            r_blank_v   <= '0;
            r_rd_buf    <= '0;
            r_pix_color <= '0;
            r_mem_addr  <= '0;
            r_mem_wdata <= '0;
            r_mem_we    <= 1'b0;
            r_wr_ack    <= 1'b0;
            r_wr_err    <= 1'b0;
            r_underrun  <= 1'b0;
        end else begin
            r_state     <= w_state_next;
            r_pend      <= w_pend_next;
            r_pend_addr <= w_pend_addr_next;
            r_wait_cnt  <= w_wait_next;
            r_wr_ack    <= w_grant;
            r_wr_err    <= w_grant & ~w_in_range;
            r_mem_we    <= w_grant & w_in_range;
            r_underrun  <= r_underrun | w_drop;
            if (w_grant) begin
                r_mem_addr  <= wr_addr;
                r_mem_wdata <= wr_data;
            end else if (w_issue) begin
                r_mem_addr <= w_issue_addr;
            end
            // Address out, RAM read, buffer, then pixel: three edges after the tick.
            r_fetch_v <= {r_fetch_v[1:0], w_issue};
            r_blank_v <= {r_blank_v[1:0], w_blank};
            if (r_fetch_v[1]) begin
                r_rd_buf <= mem_rdata;
            end
            if (r_blank_v[2]) begin
                r_pix_color <= '0;
            end else if (r_fetch_v[2]) begin
                r_pix_color <= r_rd_buf;
            end
        end
    end

`ifdef FB_UNDERRUN_CNT_EN
    logic [15:0] r_underrun_cnt;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_underrun_cnt <= '0;
        end else if (w_drop && (r_underrun_cnt != 16'hFFFF)) begin
            r_underrun_cnt <= r_underrun_cnt + 16'd1;
        end
    end

    assign underrun_count = r_underrun_cnt;
`else
    assign underrun_count = '0;
`endif

    assign wr_ack    = r_wr_ack;
    assign wr_err    = r_wr_err;
    assign mem_addr  = r_mem_addr;
    assign mem_we    = r_mem_we;
    assign mem_wdata = r_mem_wdata;
    assign pix_color = r_pix_color;
    assign underrun  = r_underrun;

endmodule

// File: tb/tb_vga_fb_arbiter.sv
// Scoreboard bench for vga_fb_arbiter with a behavioural 1-cycle-latency RAM.
module tb_vga_fb_arbiter;

    localparam int N  = 9;
    localparam int AW = 15;
    localparam int DW = 8;

`ifdef FB_UNDERRUN_CNT_EN
    localparam logic [15:0] ExpUnderrunCnt = 16'd1;
`else
    localparam logic [15:0] ExpUnderrunCnt = 16'd0;
`endif

    logic          clk = 1'b0;
    logic          reset;
    logic          pix_tick, disp_active, wr_req;
    logic [N:0]    horiz_count, vert_count;
    logic [AW-1:0] wr_addr, mem_addr;
    logic [DW-1:0] wr_data, mem_wdata, mem_rdata, pix_color;
    logic          wr_ack, wr_err, mem_we, underrun;
    logic [15:0]   underrun_count;

    logic [7:0] ram [0:32767];
    logic [7:0] exp_q[$];
    int n_cmp = 0;
    int n_fail = 0;

    vga_fb_arbiter #(
        .N        (N),
        .AW       (AW),
        .DW       (DW),
        .MAX_WAIT (8)
    ) dut (
        .clk            (clk),
        .reset          (reset),
        .pix_tick       (pix_tick),
        .disp_active    (disp_active),
        .horiz_count    (horiz_count),
        .vert_count     (vert_count),
        .wr_req         (wr_req),
        .wr_addr        (wr_addr),
        .wr_data        (wr_data),
        .wr_ack         (wr_ack),
        .wr_err         (wr_err),
        .mem_addr       (mem_addr),
        .mem_we         (mem_we),
        .mem_wdata      (mem_wdata),
        .mem_rdata      (mem_rdata),
        .pix_color      (pix_color),
        .underrun       (underrun),
        .underrun_count (underrun_count)
    );

    always #10 clk = ~clk;

    always @(posedge clk) begin
        if (mem_we) ram[mem_addr] <= mem_wdata;
        mem_rdata <= ram[mem_addr];
    end

    task automatic test_reset();
        reset = 1'b0;
        repeat (3) @(negedge clk);
        n_cmp++;
        if ({wr_ack, wr_err, mem_we, underrun} !== 4'b0000) begin
            n_fail++;
            $display("FAIL reset_flags: got %b want 0000", {wr_ack, wr_err, mem_we, underrun});
        end
        n_cmp++;
        if ({mem_addr, mem_wdata, pix_color, underrun_count} !== '0) begin
            n_fail++;
            $display("FAIL reset_data: addr=%0d wdata=%h pix=%h cnt=%0d want all 0",
                     mem_addr, mem_wdata, pix_color, underrun_count);
        end
        reset = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_fetch();
        logic [7:0] exp;
        pix_tick = 1'b1; disp_active = 1'b1; horiz_count = 10'd8; vert_count = 10'd4;
        exp_q.push_back(8'h5A);
        @(negedge clk);
        pix_tick = 1'b0;
        n_cmp++;
        if (mem_addr !== 15'd162 || mem_we !== 1'b0) begin
            n_fail++;
            $display("FAIL fetch_addr: addr=%0d we=%b want 162/0", mem_addr, mem_we);
        end
        repeat (2) @(negedge clk);
        n_cmp++;
        if (pix_color !== 8'h00) begin
            n_fail++;
            $display("FAIL fetch_early: pix=%h want 00 before third edge", pix_color);
        end
        @(negedge clk);
        exp = exp_q.pop_front();
        n_cmp++;
        if (pix_color !== exp) begin
            n_fail++;
            $display("FAIL fetch_pixel: pix=%h want %h", pix_color, exp);
        end
    endtask

    task automatic test_blank();
        logic [7:0] exp;
        pix_tick = 1'b1; disp_active = 1'b0;
        exp_q.push_back(8'h00);
        @(negedge clk);
        pix_tick = 1'b0;
        n_cmp++;
        if (mem_we !== 1'b0 || mem_addr !== 15'd162) begin
            n_fail++;
            $display("FAIL blank_noread: addr=%0d we=%b want 162/0", mem_addr, mem_we);
        end
        repeat (2) @(negedge clk);
        n_cmp++;
        if (pix_color !== 8'h5A) begin
            n_fail++;
            $display("FAIL blank_early: pix=%h want 5a", pix_color);
        end
        @(negedge clk);
        exp = exp_q.pop_front();
        n_cmp++;
        if (pix_color !== exp) begin
            n_fail++;
            $display("FAIL blank_pixel: pix=%h want %h", pix_color, exp);
        end
    endtask

    task automatic test_write();
        logic [2:0] exp_flags [$];
        logic [2:0] exp;
        exp_flags.push_back(3'b101);
        exp_flags.push_back(3'b000);
        exp_flags.push_back(3'b000);
        wr_req = 1'b1; wr_addr = 15'd100; wr_data = 8'hE0;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            exp = exp_flags.pop_front();
            n_cmp++;
            if ({wr_ack, wr_err, mem_we} !== exp) begin
                n_fail++;
                $display("FAIL write_flags[%0d]: ack/err/we=%b want %b", c, {wr_ack, wr_err, mem_we}, exp);
            end
            if (c == 0) begin
                n_cmp++;
                if (mem_addr !== 15'd100 || mem_wdata !== 8'hE0) begin
                    n_fail++;
                    $display("FAIL write_bus: addr=%0d data=%h want 100/e0", mem_addr, mem_wdata);
                end
            end
            if (c == 1) wr_req = 1'b0;
        end
        n_cmp++;
        if (ram[100] !== 8'hE0) begin
            n_fail++;
            $display("FAIL write_ram: ram[100]=%h want e0", ram[100]);
        end
    endtask

    task automatic test_write_range();
        logic [14:0] addrs [2] = '{15'd19200, 15'd19199};
        logic [2:0]  flags [2] = '{3'b110, 3'b101};
        for (int i = 0; i < 2; i++) begin
            wr_req = 1'b1; wr_addr = addrs[i]; wr_data = 8'h42;
            @(negedge clk);
            wr_req = 1'b0;
            n_cmp++;
            if ({wr_ack, wr_err, mem_we} !== flags[i]) begin
                n_fail++;
                $display("FAIL range_flags addr=%0d: ack/err/we=%b want %b",
                         addrs[i], {wr_ack, wr_err, mem_we}, flags[i]);
            end
            @(negedge clk);
            n_cmp++;
            if ({wr_ack, wr_err, mem_we} !== 3'b000) begin
                n_fail++;
                $display("FAIL range_after addr=%0d: ack/err/we=%b want 000",
                         addrs[i], {wr_ack, wr_err, mem_we});
            end
            @(negedge clk);
        end
    endtask

    task automatic test_tick_vs_write();
        logic [7:0] exp;
        pix_tick = 1'b1; disp_active = 1'b1; horiz_count = 10'd12; vert_count = 10'd8;
        wr_req = 1'b1; wr_addr = 15'd400; wr_data = 8'h11;
        exp_q.push_back(8'h7F);
        @(negedge clk);
        pix_tick = 1'b0;
        n_cmp++;
        if (wr_ack !== 1'b0 || mem_we !== 1'b0 || mem_addr !== 15'd323) begin
            n_fail++;
            $display("FAIL fetch_wins: ack=%b we=%b addr=%0d want 0/0/323", wr_ack, mem_we, mem_addr);
        end
        @(negedge clk);
        wr_req = 1'b0;
        n_cmp++;
        if (wr_ack !== 1'b1 || mem_we !== 1'b1 || mem_addr !== 15'd400) begin
            n_fail++;
            $display("FAIL write_on_return: ack=%b we=%b addr=%0d want 1/1/400", wr_ack, mem_we, mem_addr);
        end
        repeat (2) @(negedge clk);
        exp = exp_q.pop_front();
        n_cmp++;
        if (pix_color !== exp) begin
            n_fail++;
            $display("FAIL shared_pixel: pix=%h want %h", pix_color, exp);
        end
    endtask

    task automatic test_underrun_stress();
        logic [7:0] prev;
        int skipped = 0;
        int acks = 0;
        int ack_at = -1;
        n_cmp++;
        if (underrun !== 1'b0) begin
            n_fail++;
            $display("FAIL underrun_pre: underrun=%b want 0", underrun);
        end
        exp_q.delete();
        prev = pix_color;
        wr_req = 1'b1; wr_addr = 15'd5000; wr_data = 8'h99;
        for (int c = 0; c < 26; c++) begin
            if (c < 16) begin
                pix_tick = 1'b1; disp_active = 1'b1;
                horiz_count = 10'(4 * (40 + c)); vert_count = 10'd4;
                exp_q.push_back(8'(200 + c) ^ 8'h3C);
            end else begin
                pix_tick = 1'b0;
            end
            @(negedge clk);
            if (wr_ack === 1'b1) begin
                acks++;
                if (ack_at < 0) ack_at = c + 1;
                wr_req = 1'b0;
            end
            if (pix_color !== prev) begin
                prev = pix_color;
                while (exp_q.size() > 0 && exp_q[0] !== pix_color) begin
                    void'(exp_q.pop_front());
                    skipped++;
                end
                n_cmp++;
                if (exp_q.size() == 0) begin
                    n_fail++;
                    $display("FAIL stress_order: pix=%h not in remaining expected sequence", pix_color);
                end else begin
                    void'(exp_q.pop_front());
                end
            end
        end
        wr_req = 1'b0;
        n_cmp++;
        if (acks != 1 || ack_at < 1 || ack_at > 10) begin
            n_fail++;
            $display("FAIL forced_grant: acks=%0d at cycle %0d want 1 ack within 10", acks, ack_at);
        end
        n_cmp++;
        if (skipped + exp_q.size() != 1) begin
            n_fail++;
            $display("FAIL dropped_pixels: dropped=%0d want 1", skipped + exp_q.size());
        end
        n_cmp++;
        if (underrun !== 1'b1 || underrun_count !== ExpUnderrunCnt) begin
            n_fail++;
            $display("FAIL underrun_flag: flag=%b count=%0d want 1/%0d", underrun, underrun_count, ExpUnderrunCnt);
        end
        n_cmp++;
        if (ram[5000] !== 8'h99) begin
            n_fail++;
            $display("FAIL forced_write_ram: ram[5000]=%h want 99", ram[5000]);
        end
    endtask

    task automatic test_reset_mid_write();
        wr_req = 1'b1; wr_addr = 15'd300; wr_data = 8'h77;
        @(posedge clk);
        #1 reset = 1'b0;
        @(negedge clk);
        n_cmp++;
        if ({wr_ack, wr_err, mem_we, underrun} !== 4'b0000 ||
            {mem_addr, mem_wdata, pix_color, underrun_count} !== '0) begin
            n_fail++;
            $display("FAIL reset_abort: ack=%b err=%b we=%b ur=%b addr=%0d wd=%h pix=%h cnt=%0d want all 0",
                     wr_ack, wr_err, mem_we, underrun, mem_addr, mem_wdata, pix_color, underrun_count);
        end
        @(posedge clk);
        #1;
        n_cmp++;
        if (ram[300] !== 8'h10) begin
            n_fail++;
            $display("FAIL reset_no_write: ram[300]=%h want 10", ram[300]);
        end
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        wr_req = 1'b0;
        n_cmp++;
        if (wr_ack !== 1'b1 || mem_we !== 1'b1 || mem_addr !== 15'd300) begin
            n_fail++;
            $display("FAIL regrant: ack=%b we=%b addr=%0d want 1/1/300", wr_ack, mem_we, mem_addr);
        end
        repeat (2) @(negedge clk);
        n_cmp++;
        if (ram[300] !== 8'h77) begin
            n_fail++;
            $display("FAIL regrant_ram: ram[300]=%h want 77", ram[300]);
        end
    endtask

    initial begin
        for (int i = 0; i < 32768; i++) ram[i] = 8'(i) ^ 8'h3C;
        ram[162] = 8'h5A;
        reset = 1'b0; pix_tick = 1'b0; disp_active = 1'b0; wr_req = 1'b0;
        horiz_count = '0; vert_count = '0; wr_addr = '0; wr_data = '0;
        @(negedge clk);
        test_reset();
        test_fetch();
        test_blank();
        test_write();
        test_write_range();
        test_tick_vs_write();
        test_underrun_stress();
        test_reset_mid_write();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish within 200000 time units");
        $fatal(1);
    end

endmodule
